ttl_reg_bank_sync: RTL and testbench

Parametrised synchronous register bank: DEPTH registers of WIDTH bits, sharing one data input, written on a detected rising edge of a clock-enable strobe. It is the multi-register, multi-mode successor to the single octal D-register used across the TTL-sync layer, for latch/pipeline chains such as sprite-attribute staging and scroll-register banks. It runs on the one system clock with a synchronous active-high reset. It supports addressed load and shift-chain modes, an addressed read port, a tail output and a capture strobe.

---
 rtl/ttl_reg_bank_sync.sv | 107 ++++++++++
 tb/tb_ttl_reg_bank_sync.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ttl_reg_bank_sync.sv
// Synchronous register bank: DEPTH x WIDTH registers with addressed load or shift-chain capture.
// Define TTL_REG_BANK_LEVEL_CEN_EN for level-qualified Cen; the default build captures on a Cen rising edge.
module ttl_reg_bank_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Cen,
  input  logic                   Mode,
  input  logic [AW-1:0]          WrAddr,
  input  logic [WIDTH-1:0]       D,
  input  logic [AW-1:0]          RdAddr,
  output logic [WIDTH-1:0]       Q,
  output logic [WIDTH-1:0]       Qtail,
  output logic [WIDTH*DEPTH-1:0] Qall,
  output logic                   Capt
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             capt_q;
  logic             cap_s;
  logic [WIDTH-1:0] q_s;

`ifdef TTL_REG_BANK_LEVEL_CEN_EN
  assign cap_s = Cen;
`else
  logic last_cen_q;

  // Cen history; resets high so a strobe held through reset release cannot capture
  always_ff @(posedge Clk) begin
    if (Rst) begin
      last_cen_q <= 1'b1;
    end else begin
      last_cen_q <= Cen;
    end
  end

  assign cap_s = Cen & ~last_cen_q;
`endif

  // Next-state for the bank: shift chain or single addressed write on a capture
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (cap_s) begin
      if (Mode) begin
        regs_d[0] = D;
        for (int i = 1; i < DEPTH; i++) begin
          regs_d[i] = regs_q[i-1];
        end
      end else begin
        // Out-of-range addresses match no register, so nothing is written
        for (int i = 0; i < DEPTH; i++) begin
          if (WrAddr == AW'(i)) begin
            regs_d[i] = D;
          end else begin
            regs_d[i] = regs_q[i];
          end
        end
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Bank and capture-pulse registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      capt_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      capt_q <= cap_s;
    end
  end

  // Read mux; addresses beyond the bank read as zero
  always_comb begin
    q_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (RdAddr == AW'(i)) begin
        q_s = regs_q[i];
      end else begin
        q_s = q_s;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_qall
    assign Qall[g*WIDTH +: WIDTH] = regs_q[g];
  end

  assign Q     = q_s;
  assign Qtail = regs_q[DEPTH-1];
  assign Capt  = capt_q;

endmodule

// File: tb/tb_ttl_reg_bank_sync.sv
// Self-checking bench for ttl_reg_bank_sync: DEPTH=4 instance driven by a vector table
// plus hand sequences, and a DEPTH=3 instance for out-of-range addressing.
module tb_ttl_reg_bank_sync;

  logic        Clk;
  logic        Rst;
  logic        Cen, Mode;
  logic [1:0]  WrAddr, RdAddr;
  logic [7:0]  D;
  logic [7:0]  Q, Qtail;
  logic [31:0] Qall;
  logic        Capt;

  logic        Cen3, Mode3;
  logic [1:0]  WrAddr3, RdAddr3;
  logic [7:0]  D3;
  logic [7:0]  Q3, Qtail3;
  logic [23:0] Qall3;
  logic        Capt3;

  int checks = 0;
  int errors = 0;

  ttl_reg_bank_sync #(.WIDTH(8), .DEPTH(4)) u4 (
    .Clk(Clk), .Rst(Rst), .Cen(Cen), .Mode(Mode), .WrAddr(WrAddr), .D(D),
    .RdAddr(RdAddr), .Q(Q), .Qtail(Qtail), .Qall(Qall), .Capt(Capt)
  );

  ttl_reg_bank_sync #(.WIDTH(8), .DEPTH(3)) u3 (
    .Clk(Clk), .Rst(Rst), .Cen(Cen3), .Mode(Mode3), .WrAddr(WrAddr3), .D(D3),
    .RdAddr(RdAddr3), .Q(Q3), .Qtail(Qtail3), .Qall(Qall3), .Capt(Capt3)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        cen;
    logic        mode;
    logic [1:0]  wr;
    logic [7:0]  d;
    logic [1:0]  rd;
    logic [7:0]  exp_q;
    logic [7:0]  exp_tail;
    logic [31:0] exp_qall;
    logic        exp_capt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic cen, logic mode, logic [1:0] wr, logic [7:0] d, logic [1:0] rd,
                              logic [7:0] q, logic [7:0] tail, logic [31:0] qall, logic capt);
    vec_t v;
    v.cen = cen; v.mode = mode; v.wr = wr; v.d = d; v.rd = rd;
    v.exp_q = q; v.exp_tail = tail; v.exp_qall = qall; v.exp_capt = capt;
    return v;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic exp_held;
  int   capt_cnt;

  initial begin
    Rst = 1'b1; Cen = 1'b1; Mode = 1'b0; WrAddr = 2'd0; D = 8'h00; RdAddr = 2'd0;
    Cen3 = 1'b0; Mode3 = 1'b0; WrAddr3 = 2'd0; D3 = 8'h00; RdAddr3 = 2'd0;

    // Reset with Cen held high
    tick(); tick();
    chk("reset_q", Q, 8'h00);
    chk("reset_tail", Qtail, 8'h00);
    chk("reset_qall", Qall, 32'h0);
    chk("reset_capt", Capt, 1'b0);
    chk("reset_qall3", Qall3, 24'h0);

`ifdef TTL_REG_BANK_LEVEL_CEN_EN
    exp_held = 1'b1;
`else
    exp_held = 1'b0;
`endif
    Rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("held_capt[%0d]", k), Capt, exp_held);
      chk($sformatf("held_qall[%0d]", k), Qall, 32'h0);
    end

    Cen = 1'b0;
    tick();
    chk("drop_capt", Capt, 1'b0);
    Cen = 1'b1; Mode = 1'b0; WrAddr = 2'd2; D = 8'hA5; RdAddr = 2'd2;
    tick();
    chk("first_q", Q, 8'hA5);
    chk("first_qall", Qall, 32'h00A50000);
    chk("first_capt", Capt, 1'b1);
    Cen = 1'b0;
    tick();
    chk("first_capt_off", Capt, 1'b0);

    // Load then shift vectors; one-cycle Cen pulses with idle cycles between
    vecs.push_back(mk(1, 0, 0, 8'h11, 0, 8'h11, 8'h00, 32'h00A50011, 1));
    vecs.push_back(mk(0, 0, 0, 8'h00, 2, 8'hA5, 8'h00, 32'h00A50011, 0));
    vecs.push_back(mk(1, 0, 1, 8'h22, 1, 8'h22, 8'h00, 32'h00A52211, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00, 1, 8'h22, 8'h00, 32'h00A52211, 0));
    vecs.push_back(mk(1, 0, 2, 8'h33, 2, 8'h33, 8'h00, 32'h00332211, 1));
    vecs.push_back(mk(0, 0, 2, 8'h00, 0, 8'h11, 8'h00, 32'h00332211, 0));
    vecs.push_back(mk(1, 0, 3, 8'h44, 3, 8'h44, 8'h44, 32'h44332211, 1));
    vecs.push_back(mk(0, 0, 3, 8'h00, 0, 8'h11, 8'h44, 32'h44332211, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 8'h22, 8'h44, 32'h44332211, 0));
    vecs.push_back(mk(0, 1, 0, 8'hFF, 2, 8'h33, 8'h44, 32'h44332211, 0));
    vecs.push_back(mk(1, 1, 0, 8'h01, 0, 8'h01, 8'h33, 32'h33221101, 1));
    vecs.push_back(mk(0, 0, 1, 8'hFF, 1, 8'h11, 8'h33, 32'h33221101, 0));
    vecs.push_back(mk(1, 1, 0, 8'h02, 0, 8'h02, 8'h22, 32'h22110102, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 3, 8'h22, 8'h22, 32'h22110102, 0));
    vecs.push_back(mk(1, 1, 0, 8'h03, 0, 8'h03, 8'h11, 32'h11010203, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'h03, 8'h11, 32'h11010203, 0));
    vecs.push_back(mk(1, 1, 0, 8'h04, 0, 8'h04, 8'h01, 32'h01020304, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 3, 8'h01, 8'h01, 32'h01020304, 0));
    vecs.push_back(mk(1, 1, 0, 8'h05, 1, 8'h04, 8'h02, 32'h02030405, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 2, 8'h03, 8'h02, 32'h02030405, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      Cen = vecs[i].cen; Mode = vecs[i].mode; WrAddr = vecs[i].wr;
      D = vecs[i].d; RdAddr = vecs[i].rd;
      tick();
      chk($sformatf("v%0d_q", i), Q, vecs[i].exp_q);
      chk($sformatf("v%0d_tail", i), Qtail, vecs[i].exp_tail);
      chk($sformatf("v%0d_qall", i), Qall, vecs[i].exp_qall);
      chk($sformatf("v%0d_capt", i), Capt, vecs[i].exp_capt);
    end

    // Cen held high for 10 cycles in shift mode
    Cen = 1'b1; Mode = 1'b1; D = 8'hAA;
    capt_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (Capt) capt_cnt++;
    end
`ifdef TTL_REG_BANK_LEVEL_CEN_EN
    chk("held10_count", capt_cnt, 10);
    chk("held10_qall", Qall, 32'hAAAAAAAA);
`else
    chk("held10_count", capt_cnt, 1);
    chk("held10_qall", Qall, 32'h030405AA);
`endif
    Cen = 1'b0;
    tick();
    chk("held10_capt_off", Capt, 1'b0);

    // DEPTH=3: fill, then write to the nonexistent address 3
    Mode3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      Cen3 = 1'b1; WrAddr3 = 2'(k); D3 = 8'h5A + 8'(k * 17);
      tick();
      Cen3 = 1'b0;
      tick();
    end
    chk("d3_fill_qall", Qall3, 24'h7C6B5A);
    chk("d3_fill_tail", Qtail3, 8'h7C);
    Cen3 = 1'b1; WrAddr3 = 2'd3; D3 = 8'hFF; RdAddr3 = 2'd3;
    tick();
    chk("d3_oob_qall", Qall3, 24'h7C6B5A);
    chk("d3_oob_capt", Capt3, 1'b1);
    chk("d3_oob_q", Q3, 8'h00);
    Cen3 = 1'b0; RdAddr3 = 2'd1;
    tick();
    chk("d3_oob_capt_off", Capt3, 1'b0);
    chk("d3_rd1", Q3, 8'h6B);

    // Reset coincident with a capture edge on a filled bank
    Cen = 1'b1; Mode = 1'b1; D = 8'h77; Rst = 1'b1;
    tick();
    chk("rst_cap_qall", Qall, 32'h0);
    chk("rst_cap_tail", Qtail, 8'h00);
    chk("rst_cap_capt", Capt, 1'b0);
    chk("rst_cap_qall3", Qall3, 24'h0);
    Rst = 1'b0; Cen = 1'b0;
    tick();
    chk("post_rst_capt", Capt, 1'b0);
    chk("post_rst_qall", Qall, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
